// File: rtl/register_file.sv
// Architectural register file: two bypassed combinational read ports, one write-back
// port, and a per-register pending-write scoreboard that drives the decode stall.
module register_file #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 64,
  parameter int ZERO_R0  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                hazard
);

  localparam bit HARD_ZERO = (ZERO_R0 != 0);
  // Registers that can actually hold state; r0 drops out when it is hard-wired to zero.
  localparam logic [NUM_REGS-1:0] LIVE_MASK = HARD_ZERO ? ~NUM_REGS'(1) : '1;

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] busy_next;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] issue_hit;
  logic [NUM_REGS-1:0] wr_commit;

  // One-hot decode of the write-back and issue destinations.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      assign wr_hit[gi]    = wr_en    && (wr_addr    == ADDR_W'(gi));
      assign issue_hit[gi] = issue_en && (issue_dest == ADDR_W'(gi));
    end
  endgenerate

  assign wr_commit = wr_hit & LIVE_MASK;
  // A new producer issuing in the same cycle as the old one retires keeps the bit set.
  assign busy_next = (issue_hit | (busy_reg & ~wr_hit)) & LIVE_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_commit[i]) begin
          regs_reg[i] <= wr_data;
        end
      end
      busy_reg <= busy_next;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = regs_reg[addr];
    if (wr_hit[addr]) begin
      value = wr_data;
    end
    if (HARD_ZERO && (addr == '0)) begin
      value = '0;
    end
    return value;
  endfunction

  // A source with a write-back landing this cycle is served by the bypass, not stalled.
  function automatic logic src_pending(input logic [ADDR_W-1:0] addr);
    return busy_reg[addr] && !wr_hit[addr];
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
    hazard   = src_pending(rs1_addr) || src_pending(rs2_addr);
  end

  assign busy_vec = busy_reg;

endmodule
